// File: rtl/bout_sequencer.sv
// Match-level controller for the fencing bout: idle, countdown, live play,
// post-touch lockout and game over, plus the touch tally and winner flags.
module bout_sequencer #(
   parameter int COUNTDOWN_FRAMES = 180,
   parameter int LOCKOUT_FRAMES   = 60,
   parameter int TARGET_POINTS    = 5
) (
   input  logic       clk_pixel_in,
   input  logic       rst_in,
   input  logic       new_frame_in,
   input  logic       start_in,
   input  logic       pause_in,
   input  logic       action_valid_in,
   input  logic       player_scored_in,
   input  logic       opponent_scored_in,
   output logic       action_enable_out,
   output logic       round_reset_out,
   output logic [2:0] phase_out,
   output logic [7:0] countdown_out,
   output logic [3:0] player_points_out,
   output logic [3:0] opponent_points_out,
   output logic [1:0] winner_out
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAY      = 3'd2,
      LOCKOUT   = 3'd3,
      GAME_OVER = 3'd4
   } phase_t;

   localparam logic [7:0] COUNTDOWN_LOAD = 8'(COUNTDOWN_FRAMES);
   localparam logic [7:0] LOCKOUT_LOAD   = (LOCKOUT_FRAMES == 0) ? 8'd1 : 8'(LOCKOUT_FRAMES);
   localparam logic [3:0] TARGET         = 4'(TARGET_POINTS);

   phase_t     state, state_next;
   logic [7:0] counter, counter_next;
   logic [3:0] player_points, player_points_next;
   logic [3:0] opponent_points, opponent_points_next;
   logic [1:0] winner, winner_next;
   logic       action_enable, action_enable_next;
   logic       round_reset, round_reset_next;
   logic       start_q;

   logic start_rise;
   logic frame_tick;
   logic touch;

   assign start_rise = start_in & ~start_q;
   assign frame_tick = new_frame_in & ~pause_in;
   assign touch      = action_valid_in & ~pause_in & (player_scored_in | opponent_scored_in);

   // NOTE: every variable gets its hold value before the case so no path leaves
   // it unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      state_next           = state;
      counter_next         = counter;
      player_points_next   = player_points;
      opponent_points_next = opponent_points;
      winner_next          = winner;
      round_reset_next     = 1'b0;

      case (state)
         IDLE, GAME_OVER: begin
            if (start_rise) begin
               state_next           = COUNTDOWN;
               counter_next         = COUNTDOWN_LOAD;
               player_points_next   = 4'd0;
               opponent_points_next = 4'd0;
               winner_next          = 2'b00;
               round_reset_next     = 1'b1;
            end
         end
         COUNTDOWN: begin
            if (frame_tick) begin
               counter_next = counter - 8'd1;
               if (counter == 8'd1) state_next = PLAY;
            end
         end
         PLAY: begin
            // A touch wins over a coincident frame tick; the counter is simply reloaded.
            if (touch) begin
               if (player_scored_in && player_points != 4'hF)
                  player_points_next = player_points + 4'd1;
               if (opponent_scored_in && opponent_points != 4'hF)
                  opponent_points_next = opponent_points + 4'd1;
               winner_next = {opponent_points_next >= TARGET, player_points_next >= TARGET};
               if (winner_next != 2'b00) begin
                  state_next = GAME_OVER;
               end else begin
                  state_next   = LOCKOUT;
                  counter_next = LOCKOUT_LOAD;
               end
            end
         end
         LOCKOUT: begin
            if (frame_tick) begin
               counter_next = counter - 8'd1;
               if (counter == 8'd1) begin
                  state_next       = PLAY;
                  round_reset_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      action_enable_next = (state_next == PLAY) & ~pause_in;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         state           <= IDLE;
         counter         <= 8'd0;
         player_points   <= 4'd0;
         opponent_points <= 4'd0;
         winner          <= 2'b00;
         action_enable   <= 1'b0;
         round_reset     <= 1'b0;
         start_q         <= 1'b0;
      end else begin
         state           <= state_next;
         counter         <= counter_next;
         player_points   <= player_points_next;
         opponent_points <= opponent_points_next;
         winner          <= winner_next;
         action_enable   <= action_enable_next;
         round_reset     <= round_reset_next;
         start_q         <= start_in;
      end
   end

   assign action_enable_out   = action_enable;
   assign round_reset_out     = round_reset;
   assign phase_out           = state;
   assign countdown_out       = counter;
   assign player_points_out   = player_points;
   assign opponent_points_out = opponent_points;
   assign winner_out          = winner;

endmodule
